// File: rtl/conv_pixel_packer_if.sv
`default_nettype none
// ============================================================================
// conv_pixel_packer_if : sample-in / packed-word-out stream bundle
// Rev 1.0
// ============================================================================
interface conv_pixel_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, shift, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, shift, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface
`default_nettype wire

// File: rtl/conv_pixel_packer.sv
`default_nettype none
// ============================================================================
// conv_pixel_packer : shift/clip 16-bit conv results to 8-bit pixels, pack 4/word
// Rev 1.0
// ============================================================================
module conv_pixel_packer #(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_pixel_packer_if.slave   bus,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam logic [SAT_CNT_W-1:0] SAT_ONE = {{(SAT_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]           fill_q,      fill_d;
  logic [23:0]          pack_q,      pack_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q,  out_data_d;
  logic [3:0]           out_keep_q,  out_keep_d;
  logic                 out_last_q,  out_last_d;
  logic [SAT_CNT_W-1:0] sat_q,       sat_d;

  logic                 in_ready;
  logic                 accept;
  logic                 complete;
  logic signed [15:0]   shifted;
  logic                 clip_lo;
  logic                 clip_hi;
  logic [7:0]           pixel;
  logic [31:0]          merged;
  logic [3:0]           keep_new;

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    complete = accept && ((fill_q == 2'd3) || bus.in_last);
    shifted  = $signed(bus.in_data) >>> bus.shift;
    clip_lo  = shifted[15];
    clip_hi  = !shifted[15] && (|shifted[14:8]);
    pixel    = clip_lo ? 8'h00 : (clip_hi ? 8'hFF : shifted[7:0]);
    // Bytes above fill_q in pack_q are always zero, so OR-ing in the pixel is safe
    merged   = {8'h00, pack_q} | ({24'h000000, pixel} << {fill_q, 3'b000});
    case (fill_q)
      2'd0:    keep_new = 4'b0001;
      2'd1:    keep_new = 4'b0011;
      2'd2:    keep_new = 4'b0111;
      default: keep_new = 4'b1111;
    endcase
  end

  always_comb begin
    fill_d      = fill_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = merged;
      out_keep_d  = keep_new;
      out_last_d  = bus.in_last;
      fill_d      = 2'd0;
      pack_d      = 24'h000000;
    end else if (accept) begin
      pack_d = merged[23:0];
      fill_d = fill_q + 2'd1;
    end

    if (accept && (clip_lo || clip_hi) && !(&sat_q)) begin
      sat_d = sat_q + SAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 2'd0;
      pack_q      <= 24'h000000;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h00000000;
      out_keep_q  <= 4'h0;
      out_last_q  <= 1'b0;
      sat_q       <= '0;
    end else begin
      fill_q      <= fill_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;
  assign sat_count     = sat_q;

endmodule
`default_nettype wire
